// File: rtl/piano_pkg.sv
// Shared definitions for the piano playback datapath.
//   - key index constants (one-hot key code, bit0 = do .. bit6 = si)
//   - octave-4 half-period table in 100 MHz clock cycles
//   - playback FSM state encoding
//   - half_period(): note code {pitch[2:0], key[6:0]} -> half-period cycles
package piano_pkg;

   localparam int KEY_DO   = 0;
   localparam int KEY_RE   = 1;
   localparam int KEY_MI   = 2;
   localparam int KEY_FA   = 3;
   localparam int KEY_SOL  = 4;
   localparam int KEY_LA   = 5;
   localparam int KEY_SI   = 6;
   localparam int NUM_KEYS = 7;

   localparam logic [2:0] PITCH_MID = 3'd4;
   localparam int         HALF_W    = 24;

   localparam logic [HALF_W-1:0] BASE_HALF [NUM_KEYS] = '{
      24'd191110, 24'd170265, 24'd151685, 24'd143172,
      24'd127551, 24'd113636, 24'd101239
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Returns 0 for a rest (no key, or pitch 0). With several keys set,
   // scanning from the top down leaves the lowest set key in base.
   function automatic logic [HALF_W-1:0] half_period(input logic [9:0] code);
      logic [2:0]        pitch;
      logic [6:0]        key;
      logic [HALF_W-1:0] base;
      logic [HALF_W-1:0] half;
      pitch = code[9:7];
      key   = code[6:0];
      base  = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key[i]) base = BASE_HALF[i];
      end
      if (pitch == 3'd0)
         half = '0;
      else if (pitch >= PITCH_MID)
         half = base >> (pitch - PITCH_MID);
      else
         half = base << (PITCH_MID - pitch);
      return half;
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Loadable half-period counter producing a square wave.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear of counter, period and wave (priority)
//   load       : capture period, restart count, wave low
//   en         : count while high
//   period     : half-period in cycles; 0 means silent (wave held low)
//   wave       : registered square-wave output
module tone_divider
   import piano_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic              en,
   input  logic [HALF_W-1:0] period,
   output logic              wave
);

   logic [HALF_W-1:0] period_q;
   logic [HALF_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         period_q <= '0;
         wave     <= 1'b0;
      end else if (clear) begin
         cnt      <= '0;
         period_q <= '0;
         wave     <= 1'b0;
      end else if (load) begin
         cnt      <= period;
         period_q <= period;
         wave     <= 1'b0;
      end else if (en && cnt != '0) begin
         if (cnt == HALF_W'(1)) begin
            cnt  <= period_q;
            wave <= ~wave;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/tone_player.sv
// Note playback stage: accepts one note event, drives the buzzer at the
// note frequency for the requested duration, then holds a silent gap.
//   clk, rst_n    : clock, async active-low reset
//   in_valid      : producer offers a note event
//   in_ready      : accept window (IDLE and out of reset)
//   note_play     : {pitch[2:0], key[6:0]} note code
//   duration_play : note length in cycles (0 completes immediately)
//   stop          : synchronous abort, highest priority
//   speaker       : square-wave buzzer drive
//   sel           : amplifier enable (PLAY and GAP)
//   note_now      : latched note code while playing, 0 in IDLE
//   busy          : FSM not in IDLE
//   done          : one-cycle pulse on return to IDLE after a note
//
// state   | meaning
// IDLE    | waiting for a note, in_ready high
// PLAY    | tone running, duration counter counting down
// GAP     | silent gap after the tone, gap counter counting down
module tone_player
   import piano_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [9:0]  note_play,
   input  logic [31:0] duration_play,
   input  logic        stop,
   output logic        speaker,
   output logic        sel,
   output logic [9:0]  note_now,
   output logic        busy,
   output logic        done
);

   state_t      state;
   state_t      state_next;
   logic [31:0] dur_cnt;
   logic [31:0] gap_cnt;
   logic        accept;
   logic        done_next;
   logic        div_clear;
   logic        div_load;

   assign in_ready = rst_n && (state == ST_IDLE);
   assign accept   = in_valid && in_ready && !stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      div_clear  = 1'b0;
      div_load   = 1'b0;
      if (stop) begin
         state_next = ST_IDLE;
         div_clear  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (duration_play == 32'd0) begin
                     done_next = 1'b1;
                  end else begin
                     state_next = ST_PLAY;
                     div_load   = 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               if (dur_cnt <= 32'd1) begin
                  div_clear = 1'b1;
                  if (GAP_CYCLES == 0) begin
                     state_next = ST_IDLE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt <= 32'd1) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dur_cnt  <= '0;
         gap_cnt  <= '0;
         sel      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         note_now <= '0;
      end else begin
         done <= done_next;
         sel  <= (state_next != ST_IDLE);
         busy <= (state_next != ST_IDLE);

         if (stop)
            dur_cnt <= '0;
         else if (accept)
            dur_cnt <= duration_play;
         else if (state == ST_PLAY && dur_cnt != '0)
            dur_cnt <= dur_cnt - 1'b1;

         if (stop)
            gap_cnt <= '0;
         else if (state == ST_PLAY && state_next == ST_GAP)
            gap_cnt <= GAP_CYCLES;
         else if (state == ST_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;

         if (accept && duration_play != 32'd0)
            note_now <= note_play;
         else if (state_next == ST_IDLE)
            note_now <= '0;
      end
   end

   tone_divider u_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (div_clear),
      .load   (div_load),
      .en     (state == ST_PLAY),
      .period (half_period(note_play)),
      .wave   (speaker)
   );

endmodule

// File: tb/tb_tone_player.sv
module tb_tone_player;

   localparam int GAP = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  note_play = '0;
   logic [31:0] duration_play = '0;
   logic        stop = 1'b0;
   logic        speaker;
   logic        sel;
   logic [9:0]  note_now;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   tone_player #(.GAP_CYCLES(GAP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .note_play     (note_play),
      .duration_play (duration_play),
      .stop          (stop),
      .speaker       (speaker),
      .sel           (sel),
      .note_now      (note_now),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Reference half-period straight from the musical rule: octave-4 table,
   // halved per octave up, doubled per octave down, lowest key wins.
   function automatic int half_model(input logic [9:0] n);
      int base [7];
      int p;
      int idx;
      base = '{191110, 170265, 151685, 143172, 127551, 113636, 101239};
      p = int'(n[9:7]);
      idx = -1;
      for (int i = 0; i < 7; i++)
         if (n[i] && idx < 0) idx = i;
      if (p == 0 || idx < 0) return 0;
      if (p >= 4) return base[idx] / (2 ** (p - 4));
      return base[idx] * (2 ** (4 - p));
   endfunction

   // Plays one note and compares every cycle against the expected timeline:
   // k = 1..D PLAY, D+1..D+GAP GAP, D+GAP+1 done (k = 1 when D = 0).
   task automatic run_note(input logic [9:0] n, input int d, input int limit,
                           output int bad, output int first_bad,
                           output int first_rise, output int done_k);
      int h, end_k, last;
      logic e_spk, e_sel, e_done;
      logic [9:0] e_note;
      bad = 0; first_bad = -1; first_rise = -1; done_k = -1;
      h = half_model(n);
      end_k = (d == 0) ? 1 : d + GAP + 1;
      last = (limit < end_k) ? limit : end_k;
      @(negedge clk);
      in_valid = 1'b1; note_play = n; duration_play = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      note_play = 10'($urandom); duration_play = $urandom;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (k == end_k) begin
            e_done = 1'b1; e_sel = 1'b0; e_spk = 1'b0; e_note = '0;
         end else if (k <= d) begin
            e_done = 1'b0; e_sel = 1'b1; e_note = n;
            e_spk = (h == 0) ? 1'b0 : 1'(((k - 1) / h) % 2);
         end else begin
            e_done = 1'b0; e_sel = 1'b1; e_spk = 1'b0; e_note = n;
         end
         if (speaker !== e_spk || sel !== e_sel || busy !== e_sel ||
             done !== e_done || note_now !== e_note || in_ready !== e_done) begin
            bad++;
            if (first_bad < 0) first_bad = k;
         end
         if (speaker === 1'b1 && first_rise < 0) first_rise = k;
         if (done === 1'b1 && done_k < 0) done_k = k;
      end
   endtask

   task automatic test_reset();
      int bad, fb, fr, dk, low_bad;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({speaker, sel, busy, done, in_ready, note_now} !== 15'd0) begin
         errors++;
         $display("FAIL reset_initial: outputs=%b expected all 0",
                  {speaker, sel, busy, done, in_ready, note_now});
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", in_ready, busy);
      end
      run_note({3'd4, 7'b0100000}, 5000, 50, bad, fb, fr, dk);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_pre_play: bad cycles=%0d first=%0d expected 0", bad, fb);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({speaker, sel, busy, done, in_ready, note_now} !== 15'd0) begin
         errors++;
         $display("FAIL reset_mid_play: outputs=%b expected all 0",
                  {speaker, sel, busy, done, in_ready, note_now});
      end
      low_bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if ({speaker, sel, busy, done, in_ready, note_now} !== 15'd0) low_bad++;
      end
      checks++;
      if (low_bad !== 0) begin
         errors++;
         $display("FAIL reset_hold: nonzero cycles=%0d expected 0", low_bad);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || note_now !== 10'd0) begin
         errors++;
         $display("FAIL reset_after_mid: in_ready=%b busy=%b note_now=%0h expected 1 0 0",
                  in_ready, busy, note_now);
      end
   endtask

   task automatic test_a7_note();
      int bad, fb, fr, dk;
      run_note({3'd7, 7'b0100000}, 29000, 100000, bad, fb, fr, dk);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL a7_timeline: bad cycles=%0d first=%0d expected 0", bad, fb);
      end
      checks++;
      if (fr !== 1 + 14204) begin
         errors++;
         $display("FAIL a7_first_toggle: got k=%0d expected k=%0d", fr, 1 + 14204);
      end
      checks++;
      if (dk !== 1 + 29000 + GAP) begin
         errors++;
         $display("FAIL a7_done: got k=%0d expected k=%0d", dk, 1 + 29000 + GAP);
      end
   endtask

   task automatic test_multi_hot();
      int bad, fb, fr, dk;
      // pitch 7, keys sol+si: sol wins, 127551 >> 3 = 15943
      run_note({3'd7, 7'b1010000}, 17000, 100000, bad, fb, fr, dk);
      checks++;
      if (bad !== 0 || fr !== 1 + 15943) begin
         errors++;
         $display("FAIL multi_hot: bad=%0d first_toggle=%0d expected 0 %0d", bad, fr, 1 + 15943);
      end
   endtask

   task automatic test_octave_low();
      int bad, fb, fr, dk;
      // pitch 1, keys do+re: do wins, H = 1528880, so the first 3000 cycles are silent
      run_note({3'd1, 7'b0000011}, 1_600_000, 3000, bad, fb, fr, dk);
      checks++;
      if (bad !== 0 || fr !== -1 || half_model({3'd1, 7'b0000011}) != 1528880) begin
         errors++;
         $display("FAIL octave_low: bad=%0d first_toggle=%0d expected 0 -1", bad, fr);
      end
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sel !== 1'b0) begin
         errors++;
         $display("FAIL octave_low_stop: busy=%b sel=%b expected 0 0", busy, sel);
      end
   endtask

   task automatic test_rest_and_zero();
      int bad, fb, fr, dk;
      run_note({3'd4, 7'b0000000}, 500, 100000, bad, fb, fr, dk);
      checks++;
      if (bad !== 0 || fr !== -1 || dk !== 500 + GAP + 1) begin
         errors++;
         $display("FAIL rest: bad=%0d rise=%0d done_k=%0d expected 0 -1 %0d", bad, fr, dk, 500 + GAP + 1);
      end
      run_note({3'd0, 7'b0000100}, 300, 100000, bad, fb, fr, dk);
      checks++;
      if (bad !== 0 || fr !== -1) begin
         errors++;
         $display("FAIL rest_pitch0: bad=%0d rise=%0d expected 0 -1", bad, fr);
      end
      run_note({3'd5, 7'b0000001}, 0, 100000, bad, fb, fr, dk);
      checks++;
      if (bad !== 0 || dk !== 1) begin
         errors++;
         $display("FAIL zero_duration: bad=%0d done_k=%0d expected 0 1", bad, dk);
      end
   endtask

   task automatic test_stop();
      int bad, fb, fr, dk, dones;
      // B7: H = 101239 >> 3 = 12654, speaker is high when stop arrives
      run_note({3'd7, 7'b1000000}, 20000, 12700, bad, fb, fr, dk);
      checks++;
      if (bad !== 0 || fr !== 1 + 12654) begin
         errors++;
         $display("FAIL stop_pre: bad=%0d rise=%0d expected 0 %0d", bad, fr, 1 + 12654);
      end
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      checks++;
      if ({speaker, sel, busy, done, note_now} !== 14'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stop_play: spk/sel/busy/done/note=%b in_ready=%b expected 0s and 1",
                  {speaker, sel, busy, done, note_now}, in_ready);
      end
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy !== 1'b0) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL stop_no_done: bad cycles=%0d expected 0", dones);
      end
      in_valid = 1'b1; stop = 1'b1;
      note_play = {3'd7, 7'b0100000}; duration_play = 100;
      @(posedge clk); #1 in_valid = 1'b0; stop = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sel !== 1'b0 || note_now !== 10'd0) begin
         errors++;
         $display("FAIL stop_idle_accept: busy=%b sel=%b note_now=%0h expected 0 0 0", busy, sel, note_now);
      end
   endtask

   task automatic test_random();
      int bad, fb, fr, dk, d;
      logic [9:0] n;
      for (int i = 0; i < 4; i++) begin
         n = {3'($urandom_range(0, 7)), 7'($urandom_range(0, 127))};
         d = $urandom_range(0, 2000);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL random_ready[%0d]: in_ready=%b expected 1", i, in_ready);
         end
         run_note(n, d, 100000, bad, fb, fr, dk);
         checks++;
         if (bad !== 0 || dk !== ((d == 0) ? 1 : d + GAP + 1)) begin
            errors++;
            $display("FAIL random[%0d] note=%0h d=%0d: bad=%0d first=%0d done_k=%0d", i, n, d, bad, fb, dk);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] n1, n2;
      int bad, done_k2;
      n1 = {3'd6, 7'b0001000};
      n2 = {3'd5, 7'b0000010};
      @(negedge clk);
      in_valid = 1'b1; note_play = n1; duration_play = 300;
      @(posedge clk); #1;
      note_play = n2; duration_play = 200;
      bad = 0;
      for (int k = 1; k <= 300 + GAP; k++) begin
         @(negedge clk);
         if (note_now !== n1 || done !== 1'b0 || sel !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL b2b_first_note: bad cycles=%0d expected 0", bad);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b1 || note_now !== 10'd0) begin
         errors++;
         $display("FAIL b2b_done_cycle: done=%b in_ready=%b note_now=%0h expected 1 1 0", done, in_ready, note_now);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; note_play = 10'h3ff; duration_play = 5;
      @(negedge clk);
      checks++;
      if (note_now !== n2 || sel !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_entry: note_now=%0h sel=%b done=%b expected %0h 1 0", note_now, sel, done, n2);
      end
      done_k2 = -1;
      for (int k = 2; k <= 200 + GAP + 1; k++) begin
         @(negedge clk);
         if (done === 1'b1 && done_k2 < 0) done_k2 = k;
      end
      checks++;
      if (done_k2 !== 200 + GAP + 1) begin
         errors++;
         $display("FAIL b2b_second_done: got k=%0d expected k=%0d", done_k2, 200 + GAP + 1);
      end
   endtask

   initial begin
      test_reset();
      test_a7_note();
      test_multi_hot();
      test_octave_low();
      test_rest_and_zero();
      test_stop();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
